// File: rtl/axi_lite_fifo_writer.sv
// axi_lite_fifo_writer
// AXI4-Lite write master that drains a local valid/ready word stream into the
// push register of an AXI-attached FIFO, one single-beat write per word.
// Handles write responses, sticky error/timeout flags and write/drop counters.
// Optional feature macro: AXI_FIFO_WR_RETRY_EN -- when defined, a write that
// returns SLVERR/DECERR is re-issued up to MAX_RETRY times before the word is
// dropped; when undefined the first SLVERR/DECERR drops the word.
//
// Handshake semantics (all channels): a transfer happens on a rising edge where
// valid and ready are both high. A valid, once raised, stays high with stable
// payload until its transfer; ready may change freely.
module axi_lite_fifo_writer #(
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] WR_ADDR        = '0,
    parameter int                    TIMEOUT_CYCLES = 1024,
    parameter int                    MAX_RETRY      = 3
) (
    input  logic                    clk_axi,
    input  logic                    axi_resetn_i,
    input  logic [DATA_WIDTH-1:0]   src_data_i,
    input  logic                    src_valid_i,
    output logic                    src_ready_o,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [DATA_WIDTH-1:0]   axi_wdata_o,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    timeout_o,
    input  logic                    err_clear_i,
    output logic [15:0]             wr_count_o,
    output logic [7:0]              err_count_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RETRY_W    = $clog2(MAX_RETRY + 2);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    // Number of re-issues allowed per word; zero means the first failure drops.
`ifdef AXI_FIFO_WR_RETRY_EN
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
`else
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = '0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_DATA = 2'd1,
        ST_RESP      = 2'd2
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_hold;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic                    r_awvalid;
    logic                    r_wvalid;
    logic                    r_bready;
    logic                    r_err;
    logic                    r_timeout;
    logic [15:0]             r_wr_count;
    logic [7:0]              r_err_count;
    logic [WAIT_W-1:0]       r_wait;
    logic [RETRY_W-1:0]      r_retry;

    logic                    w_accept;
    logic                    w_aw_done;
    logic                    w_w_done;
    logic                    w_resp_bad;
    logic [WAIT_W-1:0]       w_wait_inc;

    // Ready only in IDLE and never while reset is asserted.
    assign src_ready_o = (r_state == ST_IDLE) && axi_resetn_i;
    assign busy_o      = (r_state != ST_IDLE);
    assign w_accept    = src_valid_i && src_ready_o;

    // A channel counts as done if its valid already dropped or it completes now.
    assign w_aw_done   = !r_awvalid || axi_awready_i;
    assign w_w_done    = !r_wvalid  || axi_wready_i;

    // SLVERR (10) and DECERR (11) are failures; OKAY and EXOKAY are success.
    assign w_resp_bad  = axi_bresp_i[1];
    assign w_wait_inc  = r_wait + WAIT_W'(1);

    assign axi_awaddr_o  = r_awaddr;
    assign axi_awvalid_o = r_awvalid;
    assign axi_wdata_o   = r_hold;
    assign axi_wstrb_o   = {STRB_WIDTH{1'b1}};
    assign axi_wvalid_o  = r_wvalid;
    assign axi_bready_o  = r_bready;
    assign err_o         = r_err;
    assign timeout_o     = r_timeout;
    assign wr_count_o    = r_wr_count;
    assign err_count_o   = r_err_count;

    // Write-sequencing FSM with its registered channel outputs, flags and counters.
    always_ff @(posedge clk_axi) begin
        if (!axi_resetn_i) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_err       <= 1'b0;
            r_timeout   <= 1'b0;
            r_wr_count  <= '0;
            r_err_count <= '0;
            r_wait      <= '0;
            r_retry     <= '0;
        end else begin
            // Clear first so that a flag set later in this block wins the cycle.
            if (err_clear_i) begin
                r_err     <= 1'b0;
                r_timeout <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hold    <= src_data_i;
                        r_awaddr  <= WR_ADDR;
                        r_retry   <= '0;
                        r_wait    <= '0;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_ADDR_DATA;
                    end
                end

                ST_ADDR_DATA: begin
                    if (r_awvalid && axi_awready_i) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && axi_wready_i) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_wait   <= '0;
                        r_state  <= ST_RESP;
                    end else if (r_wait != WAIT_MAX) begin
                        r_wait <= w_wait_inc;
                        if (w_wait_inc == WAIT_MAX) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end

                ST_RESP: begin
                    if (axi_bvalid_i) begin
                        r_bready <= 1'b0;
                        r_wait   <= '0;
                        if (!w_resp_bad) begin
                            r_wr_count <= r_wr_count + 16'd1;
                            r_state    <= ST_IDLE;
                        end else if (r_retry != RETRY_LIMIT) begin
                            r_retry   <= r_retry + RETRY_W'(1);
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_ADDR_DATA;
                        end else begin
                            r_err <= 1'b1;
                            if (r_err_count != 8'hFF) begin
                                r_err_count <= r_err_count + 8'd1;
                            end
                            r_state <= ST_IDLE;
                        end
                    end else if (r_wait != WAIT_MAX) begin
                        r_wait <= w_wait_inc;
                        if (w_wait_inc == WAIT_MAX) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
